demux_1to8_buffered: RTL and testbench

//   Write-side counterpart of the 8:1 byte read mux. Routes one 8-bit input beat to
//   one of 8 output slots (or all 8 via broadcast) by a 3-bit select.

---
 rtl/tiny_cpu_pkg.sv | 21 ++
 rtl/demux_slot.sv | 50 +++++
 rtl/demux_1to8_buffered.sv | 79 +++++++
 tb/tb_demux_1to8_buffered.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tiny_cpu_pkg.sv
// Shared constants and helpers for the tiny CPU datapath blocks.
//   DEMUX_WIDTH   : beat width of the 1:8 write demux
//   DEMUX_NUM_OUT : number of demux output slots
//   DEMUX_SEL_W   : width of the demux slot select
package tiny_cpu_pkg;

  localparam int DEMUX_WIDTH   = 8;
  localparam int DEMUX_NUM_OUT = 8;
  localparam int DEMUX_SEL_W   = 3;

  // Number of set bits in an 8-bit vector (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output slot of the 1:8 write demux: a 1-deep holding register with a
// valid flag.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture din on the next edge (slot marked valid)
//   drain      : consumer ready; clears valid unless reloaded the same cycle
//   din        : incoming beat
//   data       : held beat (kept after drain)
//   valid      : slot holds an unconsumed beat
//   free       : slot can accept a beat this cycle (empty or draining)
//   valid_nxt  : valid flag value after the next edge (ignoring reset)
module demux_slot
  import tiny_cpu_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free,
  output logic             valid_nxt
);

  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;

  assign free      = !vld_p1 || drain;
  // Refill wins over drain so a full-rate stream never drops valid.
  assign valid_nxt = load || (vld_p1 && !drain);

  // Stage p1: holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= valid_nxt;
      if (load) begin
        data_p1 <= din;
      end
    end
  end

  assign data  = data_p1;
  assign valid = vld_p1;

endmodule

// File: rtl/demux_1to8_buffered.sv
// 1:8 buffered write demux. Routes one input beat to the slot chosen by
// In_sel, or to all slots when In_bcast is set. Each slot is a 1-deep
// register with its own valid/ready handshake.
//   Clk, Reset : clock, synchronous active-high reset
//   In_data    : input beat
//   In_sel     : destination slot index
//   In_bcast   : write all slots (waits until every slot is free)
//   In_valid   : input beat present
//   In_ready   : input beat accepted when In_valid & In_ready
//   Out_data   : slot i data on [i*WIDTH +: WIDTH]
//   Out_valid  : slot i holds an unconsumed beat
//   Out_ready  : consumer i takes slot i
//   Occupied   : registered count of valid slots
module demux_1to8_buffered
  import tiny_cpu_pkg::*;
#(
  parameter int WIDTH   = DEMUX_WIDTH,
  parameter int NUM_OUT = DEMUX_NUM_OUT
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [WIDTH-1:0]         In_data,
  input  logic [DEMUX_SEL_W-1:0]   In_sel,
  input  logic                     In_bcast,
  input  logic                     In_valid,
  output logic                     In_ready,
  output logic [NUM_OUT*WIDTH-1:0] Out_data,
  output logic [NUM_OUT-1:0]       Out_valid,
  input  logic [NUM_OUT-1:0]       Out_ready,
  output logic [3:0]               Occupied
);

  logic [NUM_OUT-1:0] free;
  logic [NUM_OUT-1:0] load;
  logic [NUM_OUT-1:0] valid_nxt;
  logic               accept;
  logic [3:0]         occ_p1;

  // Ready never looks at In_valid, so producers may wait on it safely.
  assign In_ready = !Reset && (In_bcast ? (&free) : free[In_sel]);
  assign accept   = In_valid && In_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      if (In_bcast) begin
        load = '1;
      end else begin
        load[In_sel] = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (Clk),
      .rst       (Reset),
      .load      (load[i]),
      .drain     (Out_ready[i]),
      .din       (In_data),
      .data      (Out_data[i*WIDTH +: WIDTH]),
      .valid     (Out_valid[i]),
      .free      (free[i]),
      .valid_nxt (valid_nxt[i])
    );
  end

  // Stage p1: occupancy tracks the slot valid flags on the same edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      occ_p1 <= 4'd0;
    end else begin
      occ_p1 <= popcount8(valid_nxt);
    end
  end

  assign Occupied = occ_p1;

endmodule

// File: tb/tb_demux_1to8_buffered.sv
module tb_demux_1to8_buffered;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  In_data;
  logic [2:0]  In_sel;
  logic        In_bcast;
  logic        In_valid;
  logic        In_ready;
  logic [63:0] Out_data;
  logic [7:0]  Out_valid;
  logic [7:0]  Out_ready;
  logic [3:0]  Occupied;

  int n_checks = 0;
  int n_fail   = 0;

  demux_1to8_buffered dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .In_data   (In_data),
    .In_sel    (In_sel),
    .In_bcast  (In_bcast),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .Out_data  (Out_data),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Occupied  (Occupied)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [7:0] slot(input logic [63:0] d, input int i);
    return d[i*8 +: 8];
  endfunction

  function automatic logic [3:0] pop(input logic [7:0] v);
    logic [3:0] c;
    c = 0;
    for (int i = 0; i < 8; i++) if (v[i]) c++;
    return c;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Reference model for the random phase
  logic [7:0] mv;
  logic [7:0] md [8];

  initial begin
    Reset = 1'b1; In_valid = 1'b1; In_sel = 3'd0; In_bcast = 1'b0;
    In_data = 8'hFF; Out_ready = 8'h00;

    // Reset held two cycles with a beat offered
    tick(); tick();
    chk("rst_valid", Out_valid, 8'h00);
    chk("rst_occ",   Occupied,  4'd0);
    chk("rst_ready", In_ready,  1'b0);
    chk("rst_data",  Out_data,  64'h0);
    Reset = 1'b0; In_valid = 1'b0;
    tick();

    // Route to slot 5
    In_sel = 3'd5; In_data = 8'hA5; In_valid = 1'b1;
    #1 chk("route_ready", In_ready, 1'b1);
    tick();
    chk("route_valid", Out_valid, 8'b0010_0000);
    chk("route_data",  slot(Out_data, 5), 8'hA5);
    chk("route_occ",   Occupied, 4'd1);
    In_data = 8'h5A;
    #1 chk("route_full_ready", In_ready, 1'b0);
    tick();
    chk("route_hold_data",  slot(Out_data, 5), 8'hA5);
    chk("route_hold_valid", Out_valid, 8'b0010_0000);
    In_valid = 1'b0; Out_ready = 8'h20;
    tick();
    chk("drain_valid", Out_valid, 8'h00);
    chk("drain_occ",   Occupied, 4'd0);
    chk("drain_keep",  slot(Out_data, 5), 8'hA5);
    Out_ready = 8'h00;

    // Back-to-back through slot 2
    In_sel = 3'd2; In_data = 8'h77; In_valid = 1'b1;
    tick();
    Out_ready = 8'h04; In_data = 8'h11;
    #1 chk("b2b_ready1", In_ready, 1'b1);
    chk("b2b_take0", slot(Out_data, 2), 8'h77);
    tick();
    chk("b2b_valid1", Out_valid[2], 1'b1);
    chk("b2b_data1",  slot(Out_data, 2), 8'h11);
    In_data = 8'h22;
    #1 chk("b2b_ready2", In_ready, 1'b1);
    tick();
    chk("b2b_valid2", Out_valid[2], 1'b1);
    chk("b2b_data2",  slot(Out_data, 2), 8'h22);
    chk("b2b_occ",    Occupied, 4'd1);
    In_valid = 1'b0;
    tick();
    chk("b2b_drained", Out_valid, 8'h00);
    Out_ready = 8'h00;

    // Broadcast blocked by a full slot 3
    In_sel = 3'd3; In_data = 8'h33; In_valid = 1'b1;
    tick();
    In_bcast = 1'b1; In_data = 8'h3C; In_sel = 3'd0;
    #1 chk("bc_blocked", In_ready, 1'b0);
    tick();
    chk("bc_no_partial", Out_valid, 8'h08);
    chk("bc_slot3_hold", slot(Out_data, 3), 8'h33);
    Out_ready = 8'h08;
    #1 chk("bc_ready", In_ready, 1'b1);
    tick();
    chk("bc_valid", Out_valid, 8'hFF);
    chk("bc_data",  Out_data, {8{8'h3C}});
    chk("bc_occ",   Occupied, 4'd8);
    In_valid = 1'b0; In_bcast = 1'b0; Out_ready = 8'hFF;
    tick();
    chk("bc_drain", Out_valid, 8'h00);
    chk("bc_drain_occ", Occupied, 4'd0);
    Out_ready = 8'h00;

    // Reset mid-operation
    In_valid = 1'b1; In_sel = 3'd0; In_data = 8'hC0;
    tick();
    In_sel = 3'd7; In_data = 8'hC7;
    tick();
    chk("mid_pre", Out_valid, 8'h81);
    In_sel = 3'd1; In_data = 8'hC1; Reset = 1'b1;
    tick();
    chk("mid_valid", Out_valid, 8'h00);
    chk("mid_occ",   Occupied, 4'd0);
    Reset = 1'b0; In_valid = 1'b0;
    tick();
    chk("mid_slot1", Out_valid[1], 1'b0);
    chk("mid_data1", slot(Out_data, 1), 8'h00);

    // Randomised traffic against the model
    mv = 8'h00;
    for (int i = 0; i < 8; i++) md[i] = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      logic       exp_rdy;
      logic [7:0] fr;
      In_valid  = ($urandom_range(3) != 0);
      In_bcast  = ($urandom_range(7) == 0);
      In_sel    = 3'($urandom_range(7));
      In_data   = 8'($urandom);
      Out_ready = 8'($urandom);
      #1;
      fr = ~mv | Out_ready;
      exp_rdy = In_bcast ? (&fr) : fr[In_sel];
      chk("rnd_ready", In_ready, exp_rdy);
      for (int i = 0; i < 8; i++) begin
        if (mv[i] && Out_ready[i]) chk("rnd_take", slot(Out_data, i), md[i]);
      end
      for (int i = 0; i < 8; i++) begin
        if (In_valid && exp_rdy && (In_bcast || In_sel == 3'(i))) begin
          mv[i] = 1'b1;
          md[i] = In_data;
        end else if (Out_ready[i]) begin
          mv[i] = 1'b0;
        end
      end
      tick();
      chk("rnd_valid", Out_valid, mv);
      chk("rnd_occ",   Occupied, pop(Out_valid));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
